// File: rtl/plp_bus_decoder_pkg.sv
// Shared definitions for the PLP bus decoder: state encoding, drw bit positions
// and the fault register addresses used when PLP_BUS_FAULT_EN is defined.
package plp_bus_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } busState_e;

  localparam int DrwWrite = 0;
  localparam int DrwRead  = 1;

  localparam logic [31:0] FaultFlagAddr = 32'hFFFF_FFF8;
  localparam logic [31:0] FaultAddrAddr = 32'hFFFF_FFFC;

endpackage

// File: rtl/plp_bus_decoder_if.sv
// CPU-side and slave-side signals of the PLP bus decoder.
// The master modport is the CPU/peripheral view; the slave modport is the decoder view.
interface plp_bus_decoder_if #(
  parameter int NSLV = 4
);
  logic                 ie;
  logic                 de;
  logic [31:0]          iaddr;
  logic [31:0]          daddr;
  logic [1:0]           drw;
  logic [31:0]          din;
  logic [31:0]          iout;
  logic [31:0]          dout;
  logic                 stall;
  logic [NSLV-1:0]      s_ie;
  logic [NSLV-1:0]      s_de;
  logic [31:0]          s_iaddr;
  logic [31:0]          s_daddr;
  logic [1:0]           s_drw;
  logic [31:0]          s_din;
  logic [32*NSLV-1:0]   s_iout;
  logic [32*NSLV-1:0]   s_dout;

  modport master (
    output ie, de, iaddr, daddr, drw, din, s_iout, s_dout,
    input  iout, dout, stall, s_ie, s_de, s_iaddr, s_daddr, s_drw, s_din
  );

  modport slave (
    input  ie, de, iaddr, daddr, drw, din, s_iout, s_dout,
    output iout, dout, stall, s_ie, s_de, s_iaddr, s_daddr, s_drw, s_din
  );
endinterface

// File: rtl/plp_bus_decoder_slot_mux.sv
// Slot decode for one address: one-hot enable, select-field stripping and 32-bit read mux.
module plp_bus_slot_mux #(
  parameter int NSLV     = 4,
  parameter int SEL_LSB  = 20,
  parameter int SEL_BITS = 3
) (
  input  logic                en_i,
  input  logic [31:0]         addr_i,
  input  logic [32*NSLV-1:0]  rdata_i,
  output logic [NSLV-1:0]     en_o,
  output logic [31:0]         addr_o,
  output logic [31:0]         rdata_o
);

  localparam logic [31:0] SelMask = ((32'd1 << SEL_BITS) - 32'd1) << SEL_LSB;

  logic [SEL_BITS-1:0] slot;

  assign slot   = addr_i[SEL_LSB +: SEL_BITS];
  assign addr_o = addr_i & ~SelMask;

  // Slot indices at or above NSLV match no k, so unmapped accesses yield zero enables and data.
  always_comb begin
    en_o    = '0;
    rdata_o = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (en_i && (32'(slot) == k)) begin
        en_o[k] = 1'b1;
        rdata_o = rdata_i[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/plp_bus_decoder.sv
// PLP bus decoder: stalled, registered data path plus combinational instruction path.
// Optional fault flag/address registers are enabled with the macro PLP_BUS_FAULT_EN.
module plp_bus_decoder
  import plp_bus_decoder_pkg::*;
#(
  parameter int NSLV        = 4,
  parameter int SEL_LSB     = 20,
  parameter int SEL_BITS    = 3,
  parameter int WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  plp_bus_decoder_if.slave bus
);

  busState_e   state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [31:0] capAddr_q, capAddr_d;
  logic [31:0] capDin_q, capDin_d;
  logic [1:0]  capDrw_q, capDrw_d;
  logic [31:0] rdata_q, rdata_d;

  logic            stallC;
  logic [31:0]     doutC;
  logic            dataEn;
  logic            regHit;
  logic [NSLV-1:0] dSlotEn;
  logic [31:0]     dMuxData;

`ifdef PLP_BUS_FAULT_EN
  logic        faultFlag_q, faultFlag_d;
  logic [31:0] faultAddr_q, faultAddr_d;

  assign regHit = (capAddr_q == FaultFlagAddr) || (capAddr_q == FaultAddrAddr);
`else
  assign regHit = 1'b0;
`endif

  plp_bus_slot_mux #(.NSLV(NSLV), .SEL_LSB(SEL_LSB), .SEL_BITS(SEL_BITS)) u_imux (
    .en_i    (bus.ie),
    .addr_i  (bus.iaddr),
    .rdata_i (bus.s_iout),
    .en_o    (bus.s_ie),
    .addr_o  (bus.s_iaddr),
    .rdata_o (bus.iout)
  );

  plp_bus_slot_mux #(.NSLV(NSLV), .SEL_LSB(SEL_LSB), .SEL_BITS(SEL_BITS)) u_dmux (
    .en_i    (dataEn),
    .addr_i  (capAddr_q),
    .rdata_i (bus.s_dout),
    .en_o    (dSlotEn),
    .addr_o  (bus.s_daddr),
    .rdata_o (dMuxData)
  );

  assign bus.s_de  = dSlotEn;
  assign bus.s_drw = capDrw_q;
  assign bus.s_din = capDin_q;
  assign bus.stall = stallC;
  assign bus.dout  = doutC;

  // Stall is raised combinationally in the request cycle so the CPU holds immediately.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    capAddr_d = capAddr_q;
    capDin_d  = capDin_q;
    capDrw_d  = capDrw_q;
    rdata_d   = rdata_q;
    stallC    = 1'b0;
    doutC     = '0;
    dataEn    = 1'b0;
`ifdef PLP_BUS_FAULT_EN
    faultFlag_d = faultFlag_q;
    faultAddr_d = faultAddr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.de && (bus.drw != 2'b00)) begin
          capAddr_d = bus.daddr;
          capDin_d  = bus.din;
          capDrw_d  = bus.drw;
          waitCnt_d = 4'(WAIT_CYCLES);
          stallC    = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        stallC = 1'b1;
        dataEn = !regHit;
        if (waitCnt_q == 4'd0) begin
          rdata_d = capDrw_q[DrwRead] ? dMuxData : 32'd0;
          state_d = RESP;
`ifdef PLP_BUS_FAULT_EN
          // Fault registers shadow slot decode; any other unmapped access is recorded.
          if (regHit) begin
            if (capDrw_q[DrwRead]) begin
              rdata_d = (capAddr_q == FaultFlagAddr) ? {31'd0, faultFlag_q} : faultAddr_q;
            end
            if (capDrw_q[DrwWrite] && (capAddr_q == FaultFlagAddr)) begin
              faultFlag_d = 1'b0;
              faultAddr_d = '0;
            end
          end else if (dSlotEn == '0) begin
            faultFlag_d = 1'b1;
            faultAddr_d = capAddr_q;
          end
`endif
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      RESP: begin
        doutC   = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      capAddr_q <= '0;
      capDin_q  <= '0;
      capDrw_q  <= '0;
      rdata_q   <= '0;
`ifdef PLP_BUS_FAULT_EN
      faultFlag_q <= 1'b0;
      faultAddr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      capAddr_q <= capAddr_d;
      capDin_q  <= capDin_d;
      capDrw_q  <= capDrw_d;
      rdata_q   <= rdata_d;
`ifdef PLP_BUS_FAULT_EN
      faultFlag_q <= faultFlag_d;
      faultAddr_q <= faultAddr_d;
`endif
    end
  end

endmodule

// File: tb/tb_plp_bus_decoder.sv
// Directed self-checking bench for plp_bus_decoder (NSLV=4, SEL_LSB=20, WAIT_CYCLES=1).
module tb_plp_bus_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  plp_bus_decoder_if #(.NSLV(4)) bus ();

  plp_bus_decoder #(
    .NSLV(4), .SEL_LSB(20), .SEL_BITS(3), .WAIT_CYCLES(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One cycle: drive the data request just after the edge, then let outputs settle.
  task automatic applyStimulus(input logic de, input logic [1:0] drw,
                               input logic [31:0] daddr, input logic [31:0] din);
    @(posedge clk);
    #1;
    bus.de    = de;
    bus.drw   = drw;
    bus.daddr = daddr;
    bus.din   = din;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.ie     = 1'b0;
    bus.iaddr  = '0;
    bus.de     = 1'b0;
    bus.drw    = 2'b00;
    bus.daddr  = '0;
    bus.din    = '0;
    bus.s_dout = {32'h3333_4444, 32'h017D_7840, 32'h2222_1111, 32'h1111_0000};
    bus.s_iout = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_stall", 32'(bus.stall), 32'd0);
    checkOutput("rst_dout", bus.dout, 32'd0);
    checkOutput("rst_sde", 32'(bus.s_de), 32'd0);
    checkOutput("rst_sdaddr", bus.s_daddr, 32'd0);
    checkOutput("rst_sdrw", 32'(bus.s_drw), 32'd0);
    checkOutput("rst_sdin", bus.s_din, 32'd0);

    // Read slot 2; a different request during ACCESS must be ignored
    applyStimulus(1'b1, 2'b10, 32'h0020_0004, 32'd0);
    checkOutput("rd2_req_stall", 32'(bus.stall), 32'd1);
    checkOutput("rd2_req_sde", 32'(bus.s_de), 32'd0);
    applyStimulus(1'b1, 2'b01, 32'h0000_0008, 32'hDEAD_BEEF);
    checkOutput("rd2_a0_sde", 32'(bus.s_de), 32'h4);
    checkOutput("rd2_a0_sdaddr", bus.s_daddr, 32'h0000_0004);
    checkOutput("rd2_a0_sdrw", 32'(bus.s_drw), 32'h2);
    checkOutput("rd2_a0_stall", 32'(bus.stall), 32'd1);
    idleCycle();
    checkOutput("rd2_a1_sde", 32'(bus.s_de), 32'h4);
    checkOutput("rd2_a1_stall", 32'(bus.stall), 32'd1);
    checkOutput("rd2_a1_dout", bus.dout, 32'd0);
    idleCycle();
    checkOutput("rd2_resp_dout", bus.dout, 32'h017D_7840);
    checkOutput("rd2_resp_stall", 32'(bus.stall), 32'd0);
    checkOutput("rd2_resp_sde", 32'(bus.s_de), 32'd0);
    idleCycle();
    checkOutput("rd2_after_dout", bus.dout, 32'd0);

    // Write slot 1
    applyStimulus(1'b1, 2'b01, 32'h0010_0020, 32'hA5A5_A5A5);
    checkOutput("wr1_req_stall", 32'(bus.stall), 32'd1);
    idleCycle();
    checkOutput("wr1_a0_sdrw", 32'(bus.s_drw), 32'h1);
    checkOutput("wr1_a0_sdin", bus.s_din, 32'hA5A5_A5A5);
    checkOutput("wr1_a0_sde", 32'(bus.s_de), 32'h2);
    checkOutput("wr1_a0_sdaddr", bus.s_daddr, 32'h0000_0020);
    idleCycle();
    checkOutput("wr1_a1_sdin", bus.s_din, 32'hA5A5_A5A5);
    checkOutput("wr1_a1_sde", 32'(bus.s_de), 32'h2);
    idleCycle();
    checkOutput("wr1_resp_dout", bus.dout, 32'd0);
    checkOutput("wr1_resp_stall", 32'(bus.stall), 32'd0);

    // Back-to-back reads: slot 0 then slot 3, second held through the first access
    applyStimulus(1'b1, 2'b10, 32'h0000_0000, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h0030_0000, 32'd0);
    checkOutput("b2b_a0_sde", 32'(bus.s_de), 32'h1);
    applyStimulus(1'b1, 2'b10, 32'h0030_0000, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h0030_0000, 32'd0);
    checkOutput("b2b_resp0_dout", bus.dout, 32'h1111_0000);
    checkOutput("b2b_resp0_stall", 32'(bus.stall), 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h0030_0000, 32'd0);
    checkOutput("b2b_req1_stall", 32'(bus.stall), 32'd1);
    checkOutput("b2b_req1_dout", bus.dout, 32'd0);
    idleCycle();
    checkOutput("b2b_a1_sde", 32'(bus.s_de), 32'h8);
    idleCycle();
    idleCycle();
    checkOutput("b2b_resp1_dout", bus.dout, 32'h3333_4444);

    // Unmapped read of slot 5 after a read left data in the register
    applyStimulus(1'b1, 2'b10, 32'h0050_0000, 32'd0);
    idleCycle();
    checkOutput("unm_a0_sde", 32'(bus.s_de), 32'd0);
    checkOutput("unm_a0_stall", 32'(bus.stall), 32'd1);
    idleCycle();
    idleCycle();
    checkOutput("unm_resp_dout", bus.dout, 32'd0);
    checkOutput("unm_resp_stall", 32'(bus.stall), 32'd0);

`ifdef PLP_BUS_FAULT_EN
    applyStimulus(1'b1, 2'b10, 32'hFFFF_FFF8, 32'd0);
    repeat (3) idleCycle();
    checkOutput("flt_flag", bus.dout, 32'd1);
    applyStimulus(1'b1, 2'b10, 32'hFFFF_FFFC, 32'd0);
    repeat (3) idleCycle();
    checkOutput("flt_addr", bus.dout, 32'h0050_0000);
    applyStimulus(1'b1, 2'b01, 32'hFFFF_FFF8, 32'd0);
    repeat (3) idleCycle();
    applyStimulus(1'b1, 2'b10, 32'hFFFF_FFF8, 32'd0);
    repeat (3) idleCycle();
    checkOutput("flt_cleared", bus.dout, 32'd0);
`endif

    // Reset pulsed during the second ACCESS cycle of a slot-2 read
    applyStimulus(1'b1, 2'b10, 32'h0020_0004, 32'd0);
    idleCycle();
    idleCycle();
    rst = 1'b1;
    checkOutput("rst_mid_sde_before", 32'(bus.s_de), 32'h4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_sde", 32'(bus.s_de), 32'd0);
    checkOutput("rst_mid_stall", 32'(bus.stall), 32'd0);
    checkOutput("rst_mid_dout", bus.dout, 32'd0);
    idleCycle();
    checkOutput("rst_mid_dout2", bus.dout, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h0030_0000, 32'd0);
    checkOutput("rst_next_stall", 32'(bus.stall), 32'd1);
    idleCycle();
    checkOutput("rst_next_sde", 32'(bus.s_de), 32'h8);
    idleCycle();
    idleCycle();
    checkOutput("rst_next_dout", bus.dout, 32'h3333_4444);

    // Instruction side is purely combinational
    bus.ie    = 1'b1;
    bus.iaddr = 32'h0010_0010;
    #1;
    checkOutput("if_sie", 32'(bus.s_ie), 32'h2);
    checkOutput("if_siaddr", bus.s_iaddr, 32'h0000_0010);
    checkOutput("if_iout", bus.iout, 32'hA000_0001);
    checkOutput("if_stall", 32'(bus.stall), 32'd0);
    bus.iaddr = 32'h0070_0040;
    #1;
    checkOutput("if_unm_sie", 32'(bus.s_ie), 32'd0);
    checkOutput("if_unm_iout", bus.iout, 32'd0);
    checkOutput("if_unm_siaddr", bus.s_iaddr, 32'h0000_0040);
    bus.iaddr = 32'h0030_0000;
    bus.ie    = 1'b0;
    #1;
    checkOutput("if_off_iout", bus.iout, 32'd0);
    checkOutput("if_off_sie", 32'(bus.s_ie), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plp_bus_decoder.md
Name: plp_bus_decoder

Overview:
- Memory-mapped bus stage directly upstream of the PLP peripherals (cpuid, UART, LEDs, RAM).
- Takes one CPU data request, decodes the target slot from address bits and forwards the strobe with a slot-relative address.
- Waits a fixed number of cycles, registers the selected slave's read data and returns it to the CPU under a stall handshake.
- Instruction fetches are decoded and muxed combinationally with no stall.

Parameters:
- NSLV, 4: number of slave slots (1..8).
- SEL_LSB, 20: lowest address bit of the slot-select field.
- SEL_BITS, 3: width of the slot-select field; slot index = daddr[SEL_LSB +: SEL_BITS].
- WAIT_CYCLES, 1: extra cycles the data strobe is held before read data is sampled (0..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ie  in  1  CPU instruction fetch enable.
- de  in  1  CPU data request.
- iaddr  in  32  CPU instruction address.
- daddr  in  32  CPU data address.
- drw  in  2  bit0 = write, bit1 = read; 2'b00 = no-op.
- din  in  32  CPU write data.
- iout  out  32  instruction read data.
- dout  out  32  data read data.
- stall  out  1  CPU must hold its request while high.
- s_ie  out  NSLV  per-slot instruction enable.
- s_de  out  NSLV  per-slot data enable (one-hot or zero).
- s_iaddr  out  32  iaddr with the select field zeroed.
- s_daddr  out  32  captured daddr with the select field zeroed.
- s_drw  out  2  captured drw.
- s_din  out  32  captured din.
- s_iout  in  32*NSLV  slave instruction data; slot k at [32k +: 32].
- s_dout  in  32*NSLV  slave data outputs, same packing.

Behaviour:
- States: IDLE, ACCESS, RESP.
  - State register is 2 bits; wait counter is 4 bits.
  - Reset: state = IDLE, counter = 0, captured address/drw/din/read-data registers = 0, s_de = 0, stall = 0, dout = 0.
- IDLE:
  - When de=1 and drw!=0: capture daddr, drw, din and the slot index; assert stall combinationally in the same cycle; go to ACCESS with counter = WAIT_CYCLES.
  - When de=0 or drw=0: stay in IDLE, stall = 0.
- ACCESS:
  - s_de[slot] = 1 if slot < NSLV, else all s_de = 0 (unmapped access).
  - stall = 1.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: latch s_dout[slot] into the read-data register if the access is a mapped read; write 0 if unmapped or write-only. Then go to RESP.
  - ACCESS therefore lasts WAIT_CYCLES+1 cycles.
- RESP:
  - stall = 0; dout = read-data register for this one cycle.
  - Next state is IDLE. A new request is accepted only from IDLE, so back-to-back requests cost one RESP bubble.
- dout outside RESP: 0.
- Write-only accesses: dout = 0.
- drw = 2'b11: treated as read+write; both are forwarded to the slave.
- Total latency: request cycle to dout valid = WAIT_CYCLES+2 cycles.
- Request changes while stall=1 are ignored; the captured values are used throughout.
- rst asserted in any state: returns to IDLE next edge and drops s_de immediately at that edge. No partial response is returned.
- Instruction side:
  - s_ie[k] = ie && (iaddr slot == k).
  - iout = s_iout[slot]; 0 when ie=0 or the slot is unmapped.

Optional Feature:
- Macro: PLP_BUS_FAULT_EN.
- Defined: a sticky fault flag and a 32-bit fault address register, reset to 0.
  - An unmapped data access sets the flag and records the full daddr, overwriting any earlier value.
  - A read of daddr = 32'hFFFFFFF8 returns {31'b0, flag}; a read of 32'hFFFFFFFC returns the fault address.
  - Any write to 32'hFFFFFFF8 clears both registers.
  - These two addresses take priority over slot decode.
- Undefined: no fault logic; those addresses decode normally.

Decomposition:
- Shared package: state encoding (IDLE = 0, ACCESS = 1, RESP = 2), drw bit positions, fault register addresses.
- One natural sub-module, plp_bus_slot_mux: combinational slot index and range check, one-hot enable generation, and 32-bit read mux. Instantiated twice (instruction side and data side).

Test Plan:
- Reset then a read of daddr = 32'h00200004 (slot 2, WAIT_CYCLES=1) with s_dout slot 2 = 32'h017D7840: s_de = 4'b0100 for 2 cycles, s_daddr = 32'h00000004, stall high for 3 cycles, dout = 32'h017D7840 in the RESP cycle, stall low in that cycle.
- Write of din = 32'hA5A5A5A5 to slot 1: s_drw = 2'b01, s_din held at A5A5A5A5 for the whole access, dout = 0 in RESP.
- Read of slot 5 with NSLV=4: no s_de bit set, dout = 0. With PLP_BUS_FAULT_EN, a read of FFFFFFF8 returns 1 and a read of FFFFFFFC returns the offending daddr.
- Two back-to-back reads to slots 0 and 3: the second is accepted only after the RESP bubble; each returns its own slave data.
- rst pulsed during the second ACCESS cycle: s_de = 0 and state = IDLE after the edge, dout stays 0, and the next request completes normally.
- ie=1, iaddr = 32'h00100010: s_ie = 4'b0010, s_iaddr = 32'h00000010, iout equals s_iout slot 1 in the same cycle, and stall stays 0.
